// File: rtl/_dff_pipe_r_sync.sv
// WIDTH-bit, DEPTH-stage register chain with per-stage valid bits and a registered occupancy count.
// Supports hold, shift, parallel load and rotate, with a synchronous flush and a synchronous active-low reset.
module _dff_pipe_r_sync #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [WIDTH*DEPTH-1:0]   taps,
    output logic [CW-1:0]            count
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    function automatic int popcount(input logic [DEPTH-1:0] vec);
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n += int'(vec[i]);
        end
        return n;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
        stage_d = stage_q;
        valid_d = valid_q;

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = RESET_VAL;
            end
            valid_d = '0;
        end else if (en) begin
            unique case (mode_e'(mode))
                MODE_HOLD: begin
                end
                MODE_SHIFT: begin
                    stage_d[0] = d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                    valid_d = {valid_q[DEPTH-2:0], d_valid};
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_d[i] = d;
                    end
                    valid_d = {DEPTH{d_valid}};
                end
                MODE_ROTATE: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                    valid_d = {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
                end
                default: begin
                end
            endcase
        end

        // Count follows the next-state valid vector, so it can never drift from the stages it describes.
        count_d = CW'(popcount(valid_d));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; every stage is a real flop and is reset explicitly.
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            taps[i*WIDTH +: WIDTH] = stage_q[i];
        end
    end

    assign q       = stage_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb__dff_pipe_r_sync.sv
// Self-checking bench for _dff_pipe_r_sync: directed plan values plus randomized traffic
// compared against a queue-based model of the stage chain.
module tb__dff_pipe_r_sync;

    localparam int             WIDTH     = 8;
    localparam int             DEPTH     = 4;
    localparam int             CW        = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   en;
    logic                   clr;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       d;
    logic                   d_valid;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [CW-1:0]          count;

    always #5 clk = ~clk;

    _dff_pipe_r_sync #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .clr    (clr),
        .mode   (mode),
        .d      (d),
        .d_valid(d_valid),
        .q      (q),
        .q_valid(q_valid),
        .taps   (taps),
        .count  (count)
    );

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] data;
    } ent_t;

    // Model: queue front is stage 0, back is stage DEPTH-1.
    ent_t pipe[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_flush();
        ent_t e;
        e.v    = 1'b0;
        e.data = RESET_VAL;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    endtask

    task automatic model_update();
        ent_t e;
        if (!reset_n || clr) begin
            model_flush();
        end else if (en) begin
            e.v    = d_valid;
            e.data = d;
            case (mode)
                2'b01: begin
                    pipe.push_front(e);
                    void'(pipe.pop_back());
                end
                2'b10: for (int i = 0; i < DEPTH; i++) pipe[i] = e;
                2'b11: begin
                    e = pipe.pop_back();
                    pipe.push_front(e);
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic rn, input logic e, input logic c, input logic [1:0] m,
                         input logic [WIDTH-1:0] dd, input logic dv);
        reset_n = rn;
        en      = e;
        clr     = c;
        mode    = m;
        d       = dd;
        d_valid = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH*DEPTH-1:0] exp_taps;
        int                     exp_count;
        exp_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_taps[i*WIDTH +: WIDTH] = pipe[i].data;
            if (pipe[i].v) exp_count++;
        end
        check({tag, "_taps"},    64'(taps),    64'(exp_taps));
        check({tag, "_q"},       64'(q),       64'(pipe[DEPTH-1].data));
        check({tag, "_q_valid"}, 64'(q_valid), 64'(pipe[DEPTH-1].v));
        check({tag, "_count"},   64'(count),   64'(exp_count));
    endtask

    initial begin
        model_flush();

        // Reset held for two edges with busy inputs.
        drive(1'b0, 1'b1, 1'b0, 2'b01, 8'hFF, 1'b1);
        tick();
        tick();
        check_outputs("reset");
        check("reset_taps_const", 64'(taps), 64'h0);
        check("reset_count_const", 64'(count), 64'd0);

        // Fill the chain.
        drive(1'b1, 1'b1, 1'b0, 2'b01, 8'h11, 1'b1); tick(); check_outputs("fill1");
        d = 8'h22; tick(); check_outputs("fill2");
        d = 8'h33; tick(); check_outputs("fill3");
        d = 8'h44; tick(); check_outputs("fill4");
        check("fill_taps_const", 64'(taps), 64'h11223344);
        check("fill_q_const", 64'(q), 64'h11);
        check("fill_qv_const", 64'(q_valid), 64'd1);
        check("fill_count_const", 64'(count), 64'd4);

        // Hold via en=0, then via mode=00, with d moving.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
            tick();
            check("hold_en_taps", 64'(taps), 64'h11223344);
            check("hold_en_count", 64'(count), 64'd4);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b00, 8'($urandom), 1'($urandom));
            tick();
            check("hold_mode_taps", 64'(taps), 64'h11223344);
            check("hold_mode_count", 64'(count), 64'd4);
        end

        // Shift in an invalid beat.
        drive(1'b1, 1'b1, 1'b0, 2'b01, 8'h55, 1'b0);
        tick();
        check_outputs("shift_inval");
        check("shift_inval_q_const", 64'(q), 64'h22);
        check("shift_inval_count_const", 64'(count), 64'd3);

        // Load, shift one, then rotate a full turn.
        drive(1'b1, 1'b1, 1'b0, 2'b10, 8'hA5, 1'b1);
        tick();
        check("load_taps_const", 64'(taps), 64'hA5A5A5A5);
        check("load_count_const", 64'(count), 64'd4);
        drive(1'b1, 1'b1, 1'b0, 2'b01, 8'h01, 1'b1);
        tick();
        check("pre_rot_taps_const", 64'(taps), 64'hA5A5A501);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b11, 8'($urandom), 1'($urandom));
            tick();
            check_outputs("rotate");
            check("rotate_count_const", 64'(count), 64'd4);
        end
        check("rotate_return_taps", 64'(taps), 64'hA5A5A501);

        // Flush beats load; flush beats en=0.
        drive(1'b1, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b1);
        tick();
        check("clr_en_taps", 64'(taps), 64'h0);
        check("clr_en_count", 64'(count), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 8'hFF, 1'b1);
        tick();
        check("reload_count", 64'(count), 64'd4);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 8'h3C, 1'b1);
        tick();
        check("clr_noen_taps", 64'(taps), 64'h0);
        check("clr_noen_count", 64'(count), 64'd0);

        // Reset in the middle of continuous shifting, then latency from empty.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b01, 8'($urandom), 1'b1);
            tick();
            check_outputs("stream");
        end
        drive(1'b0, 1'b1, 1'b0, 2'b01, 8'($urandom), 1'b1);
        tick();
        check("midrst_taps", 64'(taps), 64'h0);
        check("midrst_qv", 64'(q_valid), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b01, 8'h77, 1'b1);
        tick();
        for (int i = 0; i < DEPTH - 1; i++) begin
            check("lat_early_qv", 64'(q_valid), 64'd0);
            drive(1'b1, 1'b1, 1'b0, 2'b01, 8'($urandom), 1'b0);
            tick();
        end
        check("lat_q", 64'(q), 64'h77);
        check("lat_qv", 64'(q_valid), 64'd1);
        check("lat_count", 64'(count), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 1'($urandom));
            tick();
            check_outputs("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
